// File: rtl/reg_ctx_unit.sv
// Context save/restore engine: walks register indices 0..NREG-1 and moves each
// register to memory (save) or each memory word back into the register file (restore).
module reg_ctx_unit #(
  parameter int NREG = 4,
  parameter int RAW  = 2,
  parameter int DW   = 8,
  parameter int MAW  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           mode,
  input  logic [MAW-1:0] base_addr,
  input  logic           hold,
  output logic [RAW-1:0] rf_rd_addr,
  input  logic [DW-1:0]  rf_rd_data,
  output logic           rf_wr_en,
  output logic [RAW-1:0] rf_wr_addr,
  output logic [DW-1:0]  rf_wr_data,
  output logic [MAW-1:0] mem_addr,
  output logic           mem_wr_en,
  output logic [DW-1:0]  mem_wr_data,
  input  logic [DW-1:0]  mem_rd_data,
  output logic           busy,
  output logic           done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [RAW-1:0] LAST_IDX = RAW'(NREG - 1);

  logic [1:0]     state;
  logic [RAW-1:0] idx;
  logic           mode_q;
  logic [MAW-1:0] base_q;

  logic in_xfer;
  logic in_done;
  logic step;
  logic do_save;
  logic do_restore;

  // Memory address wraps modulo 2^MAW by construction of the MAW-bit sum.
  function automatic logic [MAW-1:0] xfer_addr(input logic [MAW-1:0] base,
                                               input logic [RAW-1:0] i);
    xfer_addr = base + MAW'(i);
  endfunction

  // Control state: start is only honoured in IDLE, so requests while busy are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      idx    <= '0;
      mode_q <= 1'b0;
      base_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q <= mode;
            base_q <= base_addr;
            idx    <= '0;
            state  <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (!hold) begin
            if (idx == LAST_IDX) begin
              state <= ST_DONE;
            end else begin
              idx <= idx + RAW'(1);
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_xfer    = (state == ST_XFER);
  assign in_done    = (state == ST_DONE);
  assign step       = in_xfer & ~hold;
  assign do_save    = in_xfer & ~mode_q;
  assign do_restore = in_xfer &  mode_q;

  // Outputs are combinational so they hold steady through the low phase for the
  // register file's negedge write; everything outside XFER is forced to zero.
  always_comb begin
    rf_rd_addr  = '0;
    rf_wr_addr  = '0;
    rf_wr_data  = '0;
    mem_addr    = '0;
    mem_wr_data = '0;
    if (in_xfer) begin
      mem_addr = xfer_addr(base_q, idx);
    end
    if (do_save) begin
      rf_rd_addr  = idx;
      mem_wr_data = rf_rd_data;
    end
    if (do_restore) begin
      rf_wr_addr = idx;
      rf_wr_data = mem_rd_data;
    end
  end

  assign mem_wr_en = step & ~mode_q;
  assign rf_wr_en  = step &  mode_q;
  assign busy      = in_xfer | in_done;
  assign done      = in_done;

endmodule

// File: tb/tb_reg_ctx_unit.sv
// Randomized bench for reg_ctx_unit against a transfer-level model of the
// register file and data memory.
module tb_reg_ctx_unit;
  localparam int NREG = 4;
  localparam int RAW  = 2;
  localparam int DW   = 8;
  localparam int MAW  = 8;
  localparam int MSZ  = 1 << MAW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           mode = 1'b0;
  logic [MAW-1:0] base_addr = '0;
  logic           hold = 1'b0;
  logic [RAW-1:0] rf_rd_addr, rf_wr_addr;
  logic [DW-1:0]  rf_rd_data, rf_wr_data, mem_wr_data, mem_rd_data;
  logic           rf_wr_en, mem_wr_en, busy, done;
  logic [MAW-1:0] mem_addr;

  logic [DW-1:0] regs [NREG];
  logic [DW-1:0] mem  [MSZ];
  logic [DW-1:0] gold_regs [NREG];
  logic [DW-1:0] gold_mem  [MSZ];

  int vec_cnt = 0;
  int err_cnt = 0;

  reg_ctx_unit #(.NREG(NREG), .RAW(RAW), .DW(DW), .MAW(MAW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base_addr(base_addr),
    .hold(hold), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign rf_rd_data  = regs[rf_rd_addr];
  assign mem_rd_data = mem[mem_addr];

  always @(negedge clk) if (rf_wr_en)  regs[rf_wr_addr] <= rf_wr_data;
  always @(posedge clk) if (mem_wr_en) mem[mem_addr]    <= mem_wr_data;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_busy"}, 32'(busy), 0);
    check_val({tag, "_done"}, 32'(done), 0);
    check_val({tag, "_rfwe"}, 32'(rf_wr_en), 0);
    check_val({tag, "_memwe"}, 32'(mem_wr_en), 0);
    check_val({tag, "_outs"}, {rf_rd_addr, rf_wr_addr, rf_wr_data, mem_addr, mem_wr_data}, 0);
  endtask

  task automatic check_storage();
    for (int i = 0; i < NREG; i++) check_val("regs", 32'(regs[i]), 32'(gold_regs[i]));
    for (int i = 0; i < MSZ; i++)  check_val("mem", 32'(mem[i]), 32'(gold_mem[i]));
  endtask

  task automatic set_reg(input int i, input logic [DW-1:0] v);
    regs[i] = v;
    gold_regs[i] = v;
  endtask

  task automatic set_mem(input int a, input logic [DW-1:0] v);
    mem[a] = v;
    gold_mem[a] = v;
  endtask

  // One request; entered and left at posedge+1. hold_kind: 0 none, 1 random,
  // 2 two held cycles at index 2. rst_at >= 0 drops reset when that index is presented.
  task automatic run_op(input logic m, input logic [MAW-1:0] b, input int hold_kind,
                        input bit junk, input int rst_at);
    int n = 0;
    int cyc = 0;
    int holds = 0;
    int hc = 0;
    bit done_seen = 0;
    bit h;
    logic [MAW-1:0] a;
    start = 1'b1; mode = m; base_addr = b; hold = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    mode = ~m; base_addr = b ^ 8'h5A;
    forever begin
      cyc++;
      if (cyc > 40) begin
        check_val("timeout", 0, 1);
        break;
      end
      h = 1'b0;
      if (hold_kind == 1) h = ($urandom_range(0, 2) == 0);
      if (hold_kind == 2 && n == 2 && hc < 2) begin
        h = 1'b1;
        hc++;
      end
      hold = h;
      if (junk && !done_seen) begin
        start = $urandom_range(0, 1);
        mode = $urandom_range(0, 1);
        base_addr = MAW'($urandom);
      end else begin
        start = 1'b0;
      end
      if (n == rst_at && n < NREG) begin
        #1 rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_async");
        @(negedge clk); #1;
        rst_n = 1'b1;
        start = 1'b0; hold = 1'b0;
        #1;
        check_idle_outputs("rst_release");
        break;
      end
      @(negedge clk); #1;
      if (n < NREG) begin
        a = b + MAW'(n);
        check_val("busy_xfer", 32'(busy), 1);
        check_val("done_xfer", 32'(done), 0);
        check_val("mem_addr", 32'(mem_addr), 32'(a));
        check_val("mem_wr_en", 32'(mem_wr_en), 32'(!m && !h));
        check_val("rf_wr_en", 32'(rf_wr_en), 32'(m && !h));
        if (!m) begin
          check_val("rf_rd_addr", 32'(rf_rd_addr), 32'(n));
          if (!h) check_val("mem_wr_data", 32'(mem_wr_data), 32'(gold_regs[n]));
        end else begin
          check_val("rf_wr_addr", 32'(rf_wr_addr), 32'(n));
          if (!h) check_val("rf_wr_data", 32'(rf_wr_data), 32'(gold_mem[a]));
        end
        if (h) begin
          holds++;
        end else begin
          if (!m) gold_mem[a] = gold_regs[n];
          else    gold_regs[n] = gold_mem[a];
          n++;
        end
      end else if (!done_seen) begin
        check_val("done_pulse", 32'(done), 1);
        check_val("busy_done", 32'(busy), 1);
        check_val("we_in_done", 32'({rf_wr_en, mem_wr_en}), 0);
        check_val("done_latency", 32'(cyc), 32'(NREG + 1 + holds));
        done_seen = 1;
      end else begin
        check_idle_outputs("post_done");
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    hold = 1'b0;
    @(posedge clk); #1;
    check_storage();
  endtask

  initial begin
    for (int i = 0; i < MSZ; i++) set_mem(i, DW'($urandom));
    for (int i = 0; i < NREG; i++) set_reg(i, DW'($urandom));
    #3;
    check_idle_outputs("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 6; k++) begin
      hold = $urandom_range(0, 1); mode = $urandom_range(0, 1);
      base_addr = MAW'($urandom);
      @(negedge clk); #1;
      check_idle_outputs("idle");
      @(posedge clk); #1;
    end

    set_reg(0, 8'h11); set_reg(1, 8'h22); set_reg(2, 8'h33); set_reg(3, 8'h44);
    run_op(1'b0, 8'h40, 0, 0, -1);
    check_val("save_m40", 32'(mem[8'h40]), 32'h11);
    check_val("save_m43", 32'(mem[8'h43]), 32'h44);

    set_mem(8'h80, 8'hA0); set_mem(8'h81, 8'hB1); set_mem(8'h82, 8'hC2); set_mem(8'h83, 8'hD3);
    run_op(1'b1, 8'h80, 0, 0, -1);
    check_val("rest_r0", 32'(regs[0]), 32'hA0);
    check_val("rest_r3", 32'(regs[3]), 32'hD3);

    for (int i = 0; i < NREG; i++) set_reg(i, DW'($urandom));
    run_op(1'b0, 8'hFE, 0, 0, -1);
    check_val("wrap_m00", 32'(mem[8'h00]), 32'(regs[2]));

    run_op(1'b0, 8'h10, 2, 0, -1);
    run_op(1'b1, 8'h90, 2, 0, -1);
    run_op(1'b0, 8'h20, 0, 1, -1);
    run_op(1'b1, 8'hA0, 0, 1, -1);

    set_mem(8'hC0, 8'h01); set_mem(8'hC1, 8'h02); set_mem(8'hC2, 8'h03); set_mem(8'hC3, 8'h04);
    for (int i = 0; i < NREG; i++) set_reg(i, 8'hEE);
    run_op(1'b1, 8'hC0, 0, 0, 1);
    check_val("rst_r0", 32'(regs[0]), 32'h01);
    check_val("rst_r1", 32'(regs[1]), 32'hEE);
    run_op(1'b0, 8'h30, 0, 0, -1);

    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < NREG; i++) set_reg(i, DW'($urandom));
      run_op(1'($urandom_range(0, 1)), MAW'($urandom), $urandom_range(0, 1), 1'($urandom_range(0, 1)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
